data_mem_reader: RTL and testbench

- Synthesizable readout engine for the core's data memory.
- On a start command, reads a block of consecutive words through a synchronous-read memory port and streams them out over a valid/ready interface with a word index.
- Accumulates a running 32-bit checksum of the streamed words.
- Sits beside the data memory in the core/memory top. It is the extraction counterpart to memory preload, so benches and debug logic can pull results out of data memory after a program run.

---
 rtl/data_mem_reader.sv | 146 ++++++++++++++
 tb/tb_data_mem_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_reader.sv
// data_mem_reader: reads a block of consecutive words from a synchronous-read
// data memory port and streams them out over valid/ready with a word index,
// keeping a running checksum of every word the sink accepts.
module data_mem_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  // Must be at least ADDR_W+1 so that a full-memory block count fits.
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_word_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CNT_W-1:0]  o_out_index,
  output logic [DATA_W-1:0] o_checksum
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapt,
    StSend,
    StDone
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [CNT_W-1:0]    r_out_index;
  logic [DATA_W-1:0]   r_checksum;

  logic                w_handshake;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   w_sum;

  // Handshake decode and datapath arithmetic; all sums wrap naturally.
  always_comb begin
    w_handshake = r_out_valid & i_out_ready;
    w_last      = (r_remaining == CNT_W'(1));
    w_addr_next = r_addr + ADDR_W'(1);
    w_sum       = r_checksum + r_out_data;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_checksum  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_checksum <= '0;
            if (i_word_count != '0) begin
              r_addr      <= i_base_addr;
              r_remaining <= i_word_count;
              r_out_index <= '0;
              r_mem_addr  <= i_base_addr;
              r_mem_re    <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= StRead;
            end else begin
              // Empty block: report completion without touching memory.
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StRead: begin
          // Memory samples the address at this edge; data arrives next cycle.
          r_mem_re <= 1'b0;
          r_state  <= StCapt;
        end
        StCapt: begin
          r_out_data  <= i_mem_rdata;
          r_out_valid <= 1'b1;
          r_state     <= StSend;
        end
        StSend: begin
          // Without a handshake everything holds, including the memory port.
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_checksum  <= w_sum;
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_addr      <= w_addr_next;
              r_mem_addr  <= w_addr_next;
              r_mem_re    <= 1'b1;
              r_out_index <= r_out_index + CNT_W'(1);
              r_state     <= StRead;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Drive ports straight from the state registers.
  always_comb begin
    o_busy      = r_busy;
    o_done      = r_done;
    o_mem_re    = r_mem_re;
    o_mem_addr  = r_mem_addr;
    o_out_valid = r_out_valid;
    o_out_data  = r_out_data;
    o_out_index = r_out_index;
    o_checksum  = r_checksum;
  end

endmodule

// File: tb/tb_data_mem_reader.sv
// tb_data_mem_reader: directed bench for data_mem_reader with a synchronous
// memory model and a negedge monitor logging handshakes, reads and done pulses.
module tb_data_mem_reader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, mem_re, out_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, out_data, checksum;
  logic [CW-1:0] out_index;
  logic          out_ready = 1'b0;

  logic [DW-1:0] mem [1024];

  data_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_word_count (word_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_mem_re     (mem_re),
    .o_mem_addr   (mem_addr),
    .i_mem_rdata  (mem_rdata),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_index  (out_index),
    .o_checksum   (checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a handshake seen at a negedge completes on the following edge.
  int          hs_n = 0, re_n = 0, done_n = 0, vld_n = 0, done_cyc = 0;
  logic [DW-1:0] hs_data [64];
  int          hs_idx [64];
  int          hs_cyc [64];
  int          re_addr [64];
  int          re_cyc [64];
  always @(negedge clk) begin
    if (out_valid && out_ready && hs_n < 64) begin
      hs_data[hs_n] <= out_data;
      hs_idx[hs_n]  <= int'(out_index);
      hs_cyc[hs_n]  <= cyc + 1;
      hs_n          <= hs_n + 1;
    end
    if (mem_re && re_n < 64) begin
      re_addr[re_n] <= int'(mem_addr);
      re_cyc[re_n]  <= cyc;
      re_n          <= re_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (out_valid) vld_n <= vld_n + 1;
  end

  int n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns the cycle of the accepting edge.
  task automatic issue_start(input int base, input int count, output int t);
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = CW'(count);
    @(posedge clk);
    #1;
    t     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (done_n == d0 && k < 200) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_n != d0), 32'd1);
    tick(3);
  endtask

  task automatic wait_word(input int idx, input string tag);
    int k = 0;
    while (!(out_valid && int'(out_index) == idx) && k < 50) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_word_seen"}, 32'(out_valid && int'(out_index) == idx), 32'd1);
  endtask

  logic [DW-1:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  task automatic check_block4(input string tag, input int h0, input int r0);
    check_eq({tag, "_hs_count"}, 32'(hs_n - h0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_data"}, hs_data[h0 + i], exp4[i]);
      check_eq({tag, "_index"}, 32'(hs_idx[h0 + i]), 32'(i));
      check_eq({tag, "_addr"}, 32'(re_addr[r0 + i]), 32'(i));
    end
    check_eq({tag, "_checksum"}, checksum, 32'h000000AA);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, h0, r0, d0, v0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    for (int i = 0; i < 4; i++) mem[i] = exp4[i];
    mem[5] = 32'h55;

    // Asynchronous reset mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_index", 32'(out_index), 32'd0);
    check_eq("rst_checksum", checksum, 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check_eq("rel_busy", 32'(busy), 32'd0);
    check_eq("rel_done", 32'(done), 32'd0);

    // Basic dump with latency and throughput.
    out_ready = 1'b1;
    h0 = hs_n; r0 = re_n; d0 = done_n;
    issue_start(0, 4, t);
    check_eq("basic_re_t", 32'(mem_re), 32'd1);
    check_eq("basic_busy", 32'(busy), 32'd1);
    tick(1);
    check_eq("basic_re_t1", 32'(mem_re), 32'd0);
    check_eq("basic_vld_t1", 32'(out_valid), 32'd0);
    tick(1);
    check_eq("basic_vld_t2", 32'(out_valid), 32'd1);
    check_eq("basic_data_t2", out_data, 32'h11);
    wait_done(d0, "basic");
    check_block4("basic", h0, r0);
    check_eq("basic_re_cyc", 32'(re_cyc[r0]), 32'(t));
    for (int i = 0; i < 4; i++) check_eq("basic_hs_cyc", 32'(hs_cyc[h0 + i]), 32'(t + 3 + 3 * i));
    check_eq("basic_done_cyc", 32'(done_cyc), 32'(t + 12));
    check_eq("basic_done_once", 32'(done_n - d0), 32'd1);

    // Backpressure on word 1.
    h0 = hs_n; r0 = re_n; d0 = done_n;
    issue_start(0, 4, t);
    wait_word(1, "bp");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_data", out_data, 32'h22);
      check_eq("bp_index", 32'(out_index), 32'd1);
      check_eq("bp_mem_re", 32'(mem_re), 32'd0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
    end
    check_eq("bp_hs_held", 32'(hs_n - h0), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(d0, "bp");
    check_block4("bp", h0, r0);

    // Start while busy is ignored.
    h0 = hs_n; r0 = re_n; d0 = done_n;
    issue_start(0, 4, t);
    tick(3);
    start = 1'b1; base_addr = AW'(5); word_count = CW'(2);
    tick(1);
    start = 1'b0;
    wait_done(d0, "ign");
    tick(5);
    check_block4("ign", h0, r0);
    check_eq("ign_reads", 32'(re_n - r0), 32'd4);
    check_eq("ign_done_once", 32'(done_n - d0), 32'd1);

    // Zero-count start: immediate done, checksum cleared, no memory access.
    h0 = hs_n; r0 = re_n; d0 = done_n; v0 = vld_n;
    issue_start(7, 0, t);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    check_eq("zero_checksum", checksum, 32'd0);
    tick(1);
    check_eq("zero_done_low", 32'(done), 32'd0);
    tick(3);
    check_eq("zero_no_read", 32'(re_n - r0), 32'd0);
    check_eq("zero_no_valid", 32'(vld_n - v0), 32'd0);
    check_eq("zero_no_hs", 32'(hs_n - h0), 32'd0);
    check_eq("zero_done_once", 32'(done_n - d0), 32'd1);

    // Address wrap and checksum overflow.
    mem[1023] = 32'hFFFFFFFF;
    mem[0]    = 32'h00000002;
    h0 = hs_n; r0 = re_n; d0 = done_n;
    issue_start(1023, 2, t);
    wait_done(d0, "wrap");
    check_eq("wrap_addr0", 32'(re_addr[r0]), 32'h3FF);
    check_eq("wrap_addr1", 32'(re_addr[r0 + 1]), 32'h000);
    check_eq("wrap_data0", hs_data[h0], 32'hFFFFFFFF);
    check_eq("wrap_data1", hs_data[h0 + 1], 32'h00000002);
    check_eq("wrap_index1", 32'(hs_idx[h0 + 1]), 32'd1);
    check_eq("wrap_checksum", checksum, 32'h00000001);
    mem[0] = exp4[0];

    // Reset while holding word 2 of 4 in SEND.
    d0 = done_n;
    issue_start(0, 4, t);
    wait_word(1, "rmid");
    out_ready = 1'b0;
    check_eq("rmid_partial_sum", checksum, 32'h11);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmid_valid", 32'(out_valid), 32'd0);
    check_eq("rmid_checksum", checksum, 32'd0);
    check_eq("rmid_busy", 32'(busy), 32'd0);
    check_eq("rmid_index", 32'(out_index), 32'd0);
    tick(3);
    #2 rst_n = 1'b1;
    tick(4);
    check_eq("rmid_no_done", 32'(done_n - d0), 32'd0);
    check_eq("rmid_idle", 32'(busy), 32'd0);
    out_ready = 1'b1;
    h0 = hs_n; r0 = re_n; d0 = done_n;
    issue_start(0, 4, t);
    wait_done(d0, "after_rst");
    check_block4("after_rst", h0, r0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
